// File: rtl/i2c_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_bridge_pkg                                                     |
// | Register map of the I2C Avalon bridge, command entry layout and    |
// | the sequencer state encoding.                                      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package i2c_bridge_pkg;

  // Bridge register indices (write side: ADDR/DATA/RW/ENA/NBYTES,
  // read side: DATA/ACKERR). Index 5 on the write side is GPIO.
  localparam logic [2:0] REG_ADDR   = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_RW     = 3'd2;
  localparam logic [2:0] REG_ENA    = 3'd3;
  localparam logic [2:0] REG_NBYTES = 3'd4;
  localparam logic [2:0] REG_ACKERR = 3'd5;

  // One queued transaction, 43 bits.
  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [31:0] wdata;
    logic [2:0]  nbytes;
  } cmd_t;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_W_ADDR = 4'd1,
    S_W_DATA = 4'd2,
    S_W_RW   = 4'd3,
    S_W_NB   = 4'd4,
    S_W_ENA  = 4'd5,
    S_R_DATA = 4'd6,
    S_R_ACK  = 4'd7,
    S_PUSH   = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_cmd_fifo                                                       |
// | Synchronous command FIFO with occupancy count. A push into a full  |
// | FIFO is refused even when a pop happens in the same cycle.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module i2c_cmd_fifo
  import i2c_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  cmd_t                     i_data,
  input  logic                     i_pop,
  output cmd_t                     o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  cmd_t            r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [PW:0]     r_count;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | i2c_cmd_sequencer                                                  |
// | Queues I2C commands and replays each as an Avalon-MM write/read    |
// | sequence into the bridge register slave, returning data and ack.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module i2c_cmd_sequencer
  import i2c_bridge_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [6:0]                   i_cmd_addr,
  input  logic                         i_cmd_rw,
  input  logic [31:0]                  i_cmd_wdata,
  input  logic [2:0]                   i_cmd_nbytes,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic [31:0]                  o_res_rdata,
  output logic                         o_res_ack_error,
  output logic [$clog2(CMD_DEPTH):0]   o_cmd_count,
  output logic                         o_busy,
  output logic [2:0]                   o_m_address,
  output logic                         o_m_write,
  output logic [31:0]                  o_m_writedata,
  output logic                         o_m_read,
  input  logic [31:0]                  i_m_readdata,
  input  logic                         i_m_waitrequest
);

  state_t       r_state;
  logic         r_rw;
  logic [31:0]  r_wdata;
  logic [2:0]   r_nbytes;
  logic         r_m_write;
  logic         r_m_read;
  logic [2:0]   r_m_address;
  logic [31:0]  r_m_writedata;
  logic         r_res_valid;
  logic [31:0]  r_res_rdata;
  logic         r_res_ack;

  cmd_t         w_cmd_in;
  cmd_t         w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;

  assign w_cmd_in = {i_cmd_addr, i_cmd_rw, i_cmd_wdata, i_cmd_nbytes};
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;

  i2c_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (i_cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (o_cmd_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_cmd_ready     = ~w_full;
  assign o_busy          = (r_state != S_IDLE);
  assign o_m_write       = r_m_write;
  assign o_m_read        = r_m_read;
  assign o_m_address     = r_m_address;
  assign o_m_writedata   = r_m_writedata;
  assign o_res_valid     = r_res_valid;
  assign o_res_rdata     = r_res_rdata;
  assign o_res_ack_error = r_res_ack;

  // Sequencer: each transition loads the bus registers for the state being
  // entered, so every Avalon output is a flop and holds through waitrequest.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rw          <= 1'b0;
      r_wdata       <= '0;
      r_nbytes      <= '0;
      r_m_write     <= 1'b0;
      r_m_read      <= 1'b0;
      r_m_address   <= '0;
      r_m_writedata <= '0;
      r_res_valid   <= 1'b0;
      r_res_rdata   <= '0;
      r_res_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_rw     <= w_head.rw;
            r_wdata  <= w_head.wdata;
            r_nbytes <= w_head.nbytes;
            // A zero-length command is dropped silently.
            if (w_head.nbytes != 3'd0) begin
              r_state       <= S_W_ADDR;
              r_m_write     <= 1'b1;
              r_m_address   <= REG_ADDR;
              r_m_writedata <= {25'd0, w_head.addr};
            end
          end
        end
        S_W_ADDR: begin
          if (!i_m_waitrequest) begin
            r_state       <= S_W_DATA;
            r_m_address   <= REG_DATA;
            r_m_writedata <= r_wdata;
          end
        end
        S_W_DATA: begin
          if (!i_m_waitrequest) begin
            r_state       <= S_W_RW;
            r_m_address   <= REG_RW;
            r_m_writedata <= {31'd0, r_rw};
          end
        end
        S_W_RW: begin
          if (!i_m_waitrequest) begin
            r_state       <= S_W_NB;
            r_m_address   <= REG_NBYTES;
            r_m_writedata <= {29'd0, r_nbytes};
          end
        end
        S_W_NB: begin
          if (!i_m_waitrequest) begin
            r_state       <= S_W_ENA;
            r_m_address   <= REG_ENA;
            r_m_writedata <= 32'd1;
          end
        end
        S_W_ENA: begin
          if (!i_m_waitrequest) begin
            r_state     <= S_R_DATA;
            r_m_write   <= 1'b0;
            r_m_read    <= 1'b1;
            r_m_address <= REG_DATA;
          end
        end
        S_R_DATA: begin
          // Waitrequest stays high for the whole I2C transfer.
          if (!i_m_waitrequest) begin
            r_state     <= S_R_ACK;
            r_res_rdata <= i_m_readdata;
            r_m_address <= REG_ACKERR;
          end
        end
        S_R_ACK: begin
          if (!i_m_waitrequest) begin
            r_state     <= S_PUSH;
            r_res_ack   <= i_m_readdata[0];
            r_m_read    <= 1'b0;
            r_res_valid <= 1'b1;
          end
        end
        S_PUSH: begin
          if (i_res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_i2c_cmd_sequencer                                               |
// | Directed bench with a behavioural bridge slave model.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [6:0]  i_cmd_addr = '0;
  logic        i_cmd_rw = 1'b0;
  logic [31:0] i_cmd_wdata = '0;
  logic [2:0]  i_cmd_nbytes = '0;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [31:0] o_res_rdata;
  logic        o_res_ack_error;
  logic [2:0]  o_cmd_count;
  logic        o_busy;
  logic [2:0]  o_m_address;
  logic        o_m_write;
  logic [31:0] o_m_writedata;
  logic        o_m_read;
  logic [31:0] i_m_readdata;
  logic        i_m_waitrequest = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Bridge model state
  int          xfer_len = 50;
  int          wstall = 0;
  int          wcnt = 0;
  int          bbusy = 0;
  logic        rd_fixed_en = 1'b1;
  logic [31:0] rd_fixed = 32'h0000_1234;
  logic [6:0]  br_addr = '0;
  logic [31:0] br_wdata = '0;
  logic        held_v = 1'b0;
  logic [36:0] held = '0;
  logic [2:0]  wlog_idx [$];
  logic [31:0] wlog_dat [$];

  i2c_cmd_sequencer #(.CMD_DEPTH(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .i_cmd_valid     (i_cmd_valid),
    .o_cmd_ready     (o_cmd_ready),
    .i_cmd_addr      (i_cmd_addr),
    .i_cmd_rw        (i_cmd_rw),
    .i_cmd_wdata     (i_cmd_wdata),
    .i_cmd_nbytes    (i_cmd_nbytes),
    .o_res_valid     (o_res_valid),
    .i_res_ready     (i_res_ready),
    .o_res_rdata     (o_res_rdata),
    .o_res_ack_error (o_res_ack_error),
    .o_cmd_count     (o_cmd_count),
    .o_busy          (o_busy),
    .o_m_address     (o_m_address),
    .o_m_write       (o_m_write),
    .o_m_writedata   (o_m_writedata),
    .o_m_read        (o_m_read),
    .i_m_readdata    (i_m_readdata),
    .i_m_waitrequest (i_m_waitrequest)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Bridge read side: address 0x55 is the one slave that never acks.
  assign i_m_readdata = (o_m_address == 3'd5) ? {31'd0, (br_addr == 7'h55)}
                      : (rd_fixed_en ? rd_fixed : ~br_wdata);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bridge slave model, evaluated mid-cycle; sets waitrequest for the next edge.
  always @(negedge clock) begin
    if (reset) begin
      wcnt = 0;
      bbusy = 0;
      held_v = 1'b0;
      i_m_waitrequest = 1'b0;
    end else begin
      if (o_m_write || o_m_read) chk("rw_exclusive", {63'd0, o_m_write & o_m_read}, 64'd0);
      if (held_v) chk("bus_hold", {27'd0, o_m_write, o_m_read, o_m_address, o_m_writedata}, {27'd0, held});
      held_v = 1'b0;
      i_m_waitrequest = 1'b0;
      if (o_m_write) begin
        if (wcnt < wstall) begin
          wcnt++;
          i_m_waitrequest = 1'b1;
        end else begin
          wcnt = 0;
          wlog_idx.push_back(o_m_address);
          wlog_dat.push_back(o_m_writedata);
          case (o_m_address)
            3'd0: br_addr = o_m_writedata[6:0];
            3'd1: br_wdata = o_m_writedata;
            3'd3: bbusy = xfer_len;
            default: ;
          endcase
        end
      end else if (o_m_read) begin
        if (bbusy > 0) begin
          bbusy--;
          i_m_waitrequest = 1'b1;
        end
      end
      if (i_m_waitrequest) begin
        held_v = 1'b1;
        held = {o_m_write, o_m_read, o_m_address, o_m_writedata};
      end
    end
  end

  task automatic check_reset(input string tag);
    chk($sformatf("%s_ctl", tag), {58'd0, o_m_write, o_m_read, o_res_valid, o_busy, o_res_ack_error, o_cmd_ready}, 64'd1);
    chk($sformatf("%s_addr", tag), {61'd0, o_m_address}, 64'd0);
    chk($sformatf("%s_wdata", tag), {32'd0, o_m_writedata}, 64'd0);
    chk($sformatf("%s_rdata", tag), {32'd0, o_res_rdata}, 64'd0);
    chk($sformatf("%s_count", tag), {61'd0, o_cmd_count}, 64'd0);
  endtask

  task automatic push_cmd(input logic [6:0] a, input logic rw, input logic [31:0] d,
                          input logic [2:0] nb, output int t0);
    bit acc;
    acc = 1'b0;
    t0 = -1;
    @(negedge clock);
    i_cmd_valid = 1'b1; i_cmd_addr = a; i_cmd_rw = rw; i_cmd_wdata = d; i_cmd_nbytes = nb;
    for (int t = 0; t < 500 && !acc; t++) begin
      acc = o_cmd_ready;
      t0 = cyc;
      @(posedge clock);
      if (!acc) @(negedge clock);
    end
    #1 i_cmd_valid = 1'b0;
    chk("push_accept", {63'd0, acc}, 64'd1);
  endtask

  task automatic get_result(input string tag, input logic [31:0] er, input bit crd,
                            input logic ea, output int tc);
    int t;
    t = 0;
    tc = -1;
    @(negedge clock);
    while (!o_res_valid && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk($sformatf("%s_valid", tag), {63'd0, o_res_valid}, 64'd1);
    if (o_res_valid) begin
      tc = cyc;
      @(negedge clock);
      chk($sformatf("%s_held", tag), {63'd0, o_res_valid}, 64'd1);
      if (crd) chk($sformatf("%s_rdata", tag), {32'd0, o_res_rdata}, {32'd0, er});
      chk($sformatf("%s_ack", tag), {63'd0, o_res_ack_error}, {63'd0, ea});
      i_res_ready = 1'b1;
      @(posedge clock);
      #1 i_res_ready = 1'b0;
    end
  endtask

  task automatic check_wseq(input string tag, input int base, input logic [6:0] a, input logic rw,
                            input logic [31:0] d, input logic [2:0] nb);
    logic [2:0]  ei [5];
    logic [31:0] ed [5];
    logic [34:0] got;
    ei = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3};
    ed = '{{25'd0, a}, d, {31'd0, rw}, {29'd0, nb}, 32'd1};
    for (int i = 0; i < 5; i++) begin
      if (base + i < wlog_idx.size()) got = {wlog_idx[base+i], wlog_dat[base+i]};
      else got = '1;
      chk($sformatf("%s_%0d", tag, i), {29'd0, got}, {29'd0, ei[i], ed[i]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tr, nw;
    bit found, bad;

    // Reset values
    repeat (3) @(posedge clock);
    #1 check_reset("rst");
    @(negedge clock) reset = 1'b0;

    // Single read with a 50-cycle transfer
    push_cmd(7'h48, 1'b1, 32'hA5A5_0001, 3'd2, t0);
    chk("t1_count_after_push", {61'd0, o_cmd_count}, 64'd1);
    chk("t1_idle_pop_cycle", {62'd0, o_busy, o_m_write}, 64'd0);
    @(posedge clock); #1;
    chk("t1_waddr", {27'd0, o_busy, o_m_write, o_m_read, o_m_address, o_m_writedata},
        {27'd0, 1'b1, 1'b1, 1'b0, 3'd0, 32'h48});
    chk("t1_count_popped", {61'd0, o_cmd_count}, 64'd0);
    get_result("t1", 32'h0000_1234, 1'b1, 1'b0, tr);
    chk("t1_latency", 64'(tr - t0), 64'd59);
    check_wseq("t1_seq", 0, 7'h48, 1'b1, 32'hA5A5_0001, 3'd2);
    chk("t1_nwr", 64'(wlog_idx.size()), 64'd5);

    // Write command with 3-cycle stall on every write phase
    rd_fixed_en = 1'b0; wstall = 3; xfer_len = 5;
    wlog_idx.delete(); wlog_dat.delete();
    push_cmd(7'h22, 1'b0, 32'hCAFE_F00D, 3'd3, t0);
    get_result("t2", 32'h0, 1'b0, 1'b0, tr);
    check_wseq("t2_seq", 0, 7'h22, 1'b0, 32'hCAFE_F00D, 3'd3);
    chk("t2_nwr", 64'(wlog_idx.size()), 64'd5);
    wstall = 0;

    // Fill the FIFO behind a long transfer; fifth push waits for a pop
    xfer_len = 40;
    wlog_idx.delete(); wlog_dat.delete();
    push_cmd(7'h10, 1'b1, 32'h1111_0000, 3'd1, t0);
    push_cmd(7'h11, 1'b1, 32'h2222_0000, 3'd1, t0);
    push_cmd(7'h12, 1'b1, 32'h3333_0000, 3'd2, t0);
    push_cmd(7'h13, 1'b1, 32'h4444_0000, 3'd3, t0);
    push_cmd(7'h14, 1'b1, 32'h5555_0000, 3'd4, t0);
    chk("t3_full", {60'd0, o_cmd_count, o_cmd_ready}, {60'd0, 3'd4, 1'b0});
    @(negedge clock);
    i_cmd_valid = 1'b1; i_cmd_addr = 7'h15; i_cmd_rw = 1'b1;
    i_cmd_wdata = 32'h6666_0000; i_cmd_nbytes = 3'd5;
    repeat (3) @(negedge clock);
    chk("t3_refused", {60'd0, o_cmd_count, o_cmd_ready}, {60'd0, 3'd4, 1'b0});
    get_result("t3_p0", ~32'h1111_0000, 1'b1, 1'b0, tr);
    chk("t3_pop_while_full", {60'd0, o_cmd_count, o_cmd_ready}, {60'd0, 3'd4, 1'b0});
    @(posedge clock); #1;
    chk("t3_after_pop", {60'd0, o_cmd_count, o_cmd_ready}, {60'd0, 3'd3, 1'b1});
    @(posedge clock); #1;
    chk("t3_fifth_in", {60'd0, o_cmd_count, o_cmd_ready}, {60'd0, 3'd4, 1'b0});
    i_cmd_valid = 1'b0;
    xfer_len = 4;
    get_result("t3_p1", ~32'h2222_0000, 1'b1, 1'b0, tr);
    get_result("t3_p2", ~32'h3333_0000, 1'b1, 1'b0, tr);
    get_result("t3_p3", ~32'h4444_0000, 1'b1, 1'b0, tr);
    get_result("t3_p4", ~32'h5555_0000, 1'b1, 1'b0, tr);
    get_result("t3_p5", ~32'h6666_0000, 1'b1, 1'b0, tr);
    chk("t3_nwr", 64'(wlog_idx.size()), 64'd30);
    chk("t3_empty", {61'd0, o_cmd_count}, 64'd0);

    // Ack error on a write, following command still runs back-to-back
    xfer_len = 8;
    wlog_idx.delete(); wlog_dat.delete();
    push_cmd(7'h55, 1'b0, 32'h0000_00AB, 3'd1, t0);
    push_cmd(7'h50, 1'b1, 32'h0BAD_0000, 3'd2, t0);
    get_result("t4_nack", 32'h0, 1'b0, 1'b1, tr);
    chk("t4_b2b_idle", {62'd0, o_busy, o_m_write}, 64'd0);
    @(posedge clock); #1;
    chk("t4_b2b_waddr", {28'd0, o_m_write, o_m_address, o_m_writedata}, {28'd0, 1'b1, 3'd0, 32'h50});
    get_result("t4_ok", ~32'h0BAD_0000, 1'b1, 1'b0, tr);
    check_wseq("t4_seq2", 5, 7'h50, 1'b1, 32'h0BAD_0000, 3'd2);

    // Zero-length command between two real ones
    wlog_idx.delete(); wlog_dat.delete();
    push_cmd(7'h31, 1'b1, 32'h3131_0000, 3'd1, t0);
    push_cmd(7'h32, 1'b1, 32'h3232_0000, 3'd0, t0);
    push_cmd(7'h33, 1'b1, 32'h3333_3333, 3'd1, t0);
    get_result("t5_a", ~32'h3131_0000, 1'b1, 1'b0, tr);
    get_result("t5_b", ~32'h3333_3333, 1'b1, 1'b0, tr);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      bad |= o_res_valid | o_busy;
    end
    chk("t5_no_extra", {63'd0, bad}, 64'd0);
    chk("t5_nwr", 64'(wlog_idx.size()), 64'd10);
    check_wseq("t5_seq_b", 5, 7'h33, 1'b1, 32'h3333_3333, 3'd1);

    // Reset during R_DATA with two commands queued
    xfer_len = 100;
    wlog_idx.delete(); wlog_dat.delete();
    push_cmd(7'h41, 1'b1, 32'h4141_0000, 3'd1, t0);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clock);
      found = o_m_read && (o_m_address == 3'd1);
    end
    chk("t6_in_rdata", {63'd0, found}, 64'd1);
    push_cmd(7'h42, 1'b1, 32'h4242_0000, 3'd1, t0);
    push_cmd(7'h43, 1'b1, 32'h4343_0000, 3'd1, t0);
    chk("t6_queued", {61'd0, o_cmd_count}, 64'd2);
    nw = wlog_idx.size();
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset("t6_rst");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clock);
      bad |= o_m_write | o_m_read | o_res_valid | o_busy;
    end
    chk("t6_quiet", {63'd0, bad}, 64'd0);
    chk("t6_count", {61'd0, o_cmd_count}, 64'd0);
    chk("t6_nwr", 64'(wlog_idx.size()), 64'(nw));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Upstream command sequencer for the I2C Avalon bridge. It accepts I2C transactions on a valid/ready command port and buffers them in a small FIFO. It replays each one as an Avalon-MM master write/read sequence into the bridge's register slave, and returns read data plus ack status on a valid/ready result port. Software or a polling engine can then queue sensor transactions without spinning on the bridge's waitrequest.

## Interface

Parameters:
- `CMD_DEPTH`, 4: command FIFO depth; power of two, ≥2.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  FIFO not full
- `cmd_addr`  in  7  I2C slave address
- `cmd_rw`  in  1  1 = read, 0 = write
- `cmd_wdata`  in  32  write payload
- `cmd_nbytes`  in  3  bytes to transfer
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed
- `res_rdata`  out  32  bridge data register after transaction
- `res_ack_error`  out  1  bridge ack_error after transaction
- `cmd_count`  out  $clog2(CMD_DEPTH)+1  FIFO occupancy
- `busy`  out  1  FSM not IDLE
- `m_address`  out  3  bridge register index
- `m_write`  out  1  Avalon write
- `m_writedata`  out  32  Avalon write data
- `m_read`  out  1  Avalon read
- `m_readdata`  in  32  Avalon read data, combinational, zero latency
- `m_waitrequest`  in  1  bridge stall; high while the bridge's ena is set

## Operation

Bridge register map:
- Writes: 0 addr, 1 wdata, 2 rw, 3 ena, 4 number_of_bytes.
- Reads: 1 rdata, 5 ack_error.
- Write 5 is the GPIO register. This block never writes index 5.

FSM states and transitions:
- IDLE: if the FIFO is non-empty, pop into working registers.
  - `nbytes` == 0: discard the command; no bus traffic, no result; stay IDLE.
  - Otherwise go to W_ADDR.
- W_ADDR → W_DATA → W_RW → W_NB → W_ENA: each state drives `m_write`=1 with index 0/1/2/4/3 and data addr (zero-extended) / wdata / rw / nbytes / 1.
  - Each state advances only on a cycle with `m_waitrequest`=0.
- W_ENA → R_DATA.
- R_DATA: `m_read`=1, index 1. Hold until `m_waitrequest`=0, which signals the transaction is done. Capture `m_readdata` into `res_rdata` that cycle; go to R_ACK.
- R_ACK: `m_read`=1, index 5. On `m_waitrequest`=0, capture bit 0 into `res_ack_error`; go to PUSH.
- PUSH: `res_valid`=1. On `res_ready`=1 go to IDLE.

Result and FIFO rules:
- The result is held stable while `res_valid` is high.
- Write commands also produce a result; `res_rdata` is don't-care for them.
- FIFO push happens on `cmd_valid & cmd_ready`.
- `cmd_ready` = count < CMD_DEPTH.
- Push and pop in the same cycle leave the count unchanged. A full FIFO refuses pushes even if a pop occurs that cycle.
- Pointers wrap modulo CMD_DEPTH.

## Timing

Reset values (all outputs):
- `m_write`, `m_read`, `res_valid`, `busy`, `res_ack_error` = 0.
- `m_address`, `m_writedata`, `res_rdata` = 0.
- `cmd_count` = 0; `cmd_ready` = 1.
- FSM = IDLE; FIFO is emptied.

Reset mid-transaction:
- Abandons the sequence.
- Issues no further bus cycles.
- The bridge is reset by the same signal.

Avalon outputs:
- All are registered.
- `m_address`, `m_writedata`, `m_write`, `m_read` stay constant while `m_waitrequest` is high.
- `m_write` and `m_read` are never both high.

Latency with `m_waitrequest`=0 throughout, except during the I2C transfer:
- Push at cycle 0; pop at 1.
- Writes in cycles 2–6.
- R_DATA starts at cycle 7 and stalls for the transfer duration.
- R_ACK occupies one cycle; `res_valid` rises the cycle after R_ACK completes.

Other rules:
- Back-to-back: IDLE → W_ADDR of the next command occurs the cycle after PUSH handshake.
- `busy` = 1 in every state except IDLE.

## Structure

- Package `i2c_bridge_pkg`: register index constants (REG_ADDR=0, REG_DATA=1, REG_RW=2, REG_ENA=3, REG_ACKERR=5, REG_NBYTES=4) and the FSM state enum.
- Sub-module `i2c_cmd_fifo`: synchronous FIFO, 43-bit entries {addr, rw, wdata, nbytes}, exposes count/full/empty.
- Top: FSM, working registers, result register.

## Test plan

- Single read: addr 0x48, rw=1, nbytes=2; bridge model stalls 50 cycles, returns 0x0000_1234, ack_error 0 → write sequence on indices 0,1,2,4,3 with data 0x48,wdata,1,2,1; then `res_rdata`=0x1234, `res_ack_error`=0.
- Waitrequest stall on every write phase (3 cycles each) → address/data held stable, each index written exactly once, order unchanged.
- Fill: push 5 commands with no drain and bridge stalled, CMD_DEPTH=4 → `cmd_ready` low after the 4th accepted entry, a 5th push is accepted only after the first pop; results come out in push order.
- Ack error: bridge returns ack_error=1 on a write command → `res_ack_error`=1; next queued command still executes.
- nbytes=0 command between two valid commands → no bus traffic for it, exactly two results.
- Reset asserted during R_DATA with 2 entries queued → next cycle all outputs at reset values, `cmd_count`=0, no result emitted.
